// File: rtl/fifo_rd_stream.sv
// Read-side drain stage for the async FIFO: pops words into a 3-entry buffer
// and presents them as a valid/ready stream, with a wrapping delivered-word counter.
module fifo_rd_stream #(
    parameter int    DSIZE       = 16,
    parameter string FALLTHROUGH = "FALSE",
    parameter int    CNTW        = 32
) (
    input  logic             rclk,
    input  logic             rrst_n,
    input  logic             rempty,
    input  logic [DSIZE-1:0] rdata,
    output logic             rinc,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [DSIZE-1:0] m_data,
    output logic [CNTW-1:0]  rd_count,
    output logic [1:0]       buf_level
);

    localparam bit            SHOW_AHEAD = (FALLTHROUGH == "TRUE");
    localparam logic [CNTW-1:0] CNT_ONE  = {{(CNTW-1){1'b0}}, 1'b1};

    logic [1:0]       occ;
    logic [1:0]       head;
    logic [1:0]       tail;
    logic             inflight;
    logic [DSIZE-1:0] entry [3];
    logic [2:0]       credit;
    logic             capture;
    logic             pop;

    function automatic logic [1:0] wrap_inc(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    // Credit counts words already held plus the one still on its way from the FIFO,
    // so a pop is only issued when there is guaranteed room to land it.
    assign credit  = {1'b0, occ} + {2'b00, inflight};
    assign rinc    = rrst_n && !rempty && (credit < 3'd3);
    assign capture = SHOW_AHEAD ? rinc : inflight;
    assign pop     = m_valid && m_ready;

    assign m_valid   = (occ != 2'd0);
    assign buf_level = occ;

    always_comb begin
        m_data = entry[0];
        if (head == 2'd1)
            m_data = entry[1];
        else if (head == 2'd2)
            m_data = entry[2];
    end

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            occ      <= 2'd0;
            head     <= 2'd0;
            tail     <= 2'd0;
            inflight <= 1'b0;
            rd_count <= '0;
            for (int i = 0; i < 3; i++)
                entry[i] <= '0;
        end else begin
            inflight <= SHOW_AHEAD ? 1'b0 : rinc;
            if (capture) begin
                for (int i = 0; i < 3; i++)
                    if (tail == i[1:0])
                        entry[i] <= rdata;
                tail <= wrap_inc(tail);
            end
            if (pop) begin
                head     <= wrap_inc(head);
                rd_count <= rd_count + CNT_ONE;
            end
            occ <= occ + {1'b0, capture} - {1'b0, pop};
        end
    end

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Bench for fifo_rd_stream: three instances (registered read, show-ahead, 4-bit counter)
// fed from queue-based FIFO models in lock-step, checked against a word scoreboard.
module tb_fifo_rd_stream;
    localparam int DW = 16;

    logic          rclk = 1'b0;
    logic          rrst_n = 1'b0;
    logic          m_ready = 1'b1;
    logic          rempty  [3];
    logic [DW-1:0] rdata   [3];
    logic          rinc    [3];
    logic          m_valid [3];
    logic [DW-1:0] m_data  [3];
    logic [1:0]    bl      [3];
    logic [31:0]   cnt_f, cnt_t;
    logic [3:0]    cnt_c;

    int total = 0;
    int bad   = 0;

    logic [DW-1:0] fq [3][$];
    logic [DW-1:0] sb [3][$];
    logic          r_prev    [3];
    int            delivered [3];
    int            pulses    [3];

    typedef struct {
        int          n;
        logic [15:0] first;
        logic        ready;
        int          cycles;
        int          pulses;
        int          level;
        int          deliv;
        logic        chk_head;
        logic [15:0] head;
    } row_t;
    row_t tbl [4];

    always #5 rclk = ~rclk;

    fifo_rd_stream #(.DSIZE(DW), .FALLTHROUGH("FALSE"), .CNTW(32)) dut_f (
        .rclk(rclk), .rrst_n(rrst_n), .rempty(rempty[0]), .rdata(rdata[0]),
        .rinc(rinc[0]), .m_valid(m_valid[0]), .m_ready(m_ready), .m_data(m_data[0]),
        .rd_count(cnt_f), .buf_level(bl[0]));

    fifo_rd_stream #(.DSIZE(DW), .FALLTHROUGH("TRUE"), .CNTW(32)) dut_t (
        .rclk(rclk), .rrst_n(rrst_n), .rempty(rempty[1]), .rdata(rdata[1]),
        .rinc(rinc[1]), .m_valid(m_valid[1]), .m_ready(m_ready), .m_data(m_data[1]),
        .rd_count(cnt_t), .buf_level(bl[1]));

    fifo_rd_stream #(.DSIZE(DW), .FALLTHROUGH("FALSE"), .CNTW(4)) dut_c (
        .rclk(rclk), .rrst_n(rrst_n), .rempty(rempty[2]), .rdata(rdata[2]),
        .rinc(rinc[2]), .m_valid(m_valid[2]), .m_ready(m_ready), .m_data(m_data[2]),
        .rd_count(cnt_c), .buf_level(bl[2]));

    function automatic logic [31:0] cnt(input int i);
        case (i)
            0:       return cnt_f;
            1:       return cnt_t;
            default: return {28'd0, cnt_c};
        endcase
    endfunction

    task automatic chk(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s dut%0d got=%0h want=%0h", nm, i, act, exp);
        end
    endtask

    task automatic fail(input string nm);
        total++;
        bad++;
        $display("FAIL %s", nm);
    endtask

    // Show-ahead FIFO presents its head word continuously; the registered one
    // only updates rdata when a pop completes.
    task automatic refresh(input int i);
        rempty[i] = (fq[i].size() == 0);
        if (i == 1)
            rdata[1] = (fq[1].size() != 0) ? fq[1][0] : '0;
    endtask

    task automatic push(input logic [DW-1:0] w);
        for (int i = 0; i < 3; i++) begin
            fq[i].push_back(w);
            sb[i].push_back(w);
            refresh(i);
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < 3; i++) begin
            fq[i].delete();
            sb[i].delete();
            r_prev[i]    = 1'b0;
            delivered[i] = 0;
            rdata[i]     = '0;
            refresh(i);
        end
    endtask

    // One clock: sample mid-cycle, advance the edge, then check the outcome
    // and apply the FIFO's response to any pop issued in that cycle.
    task automatic cycle();
        logic          r_s [3];
        logic          v_s [3];
        logic          acc [3];
        logic [DW-1:0] d_s [3];
        int            l_s [3];
        int            exp_l;
        logic          cap;
        logic [DW-1:0] w;
        #1;
        for (int i = 0; i < 3; i++) begin
            r_s[i] = rinc[i];
            v_s[i] = m_valid[i];
            d_s[i] = m_data[i];
            l_s[i] = int'(bl[i]);
            acc[i] = v_s[i] && m_ready;
            chk("rinc_vs_empty", i, {31'd0, r_s[i] && rempty[i]}, 32'd0);
            if (acc[i]) begin
                if (sb[i].size() == 0)
                    fail("extra_beat");
                else
                    chk("beat_data", i, {16'd0, d_s[i]}, {16'd0, sb[i].pop_front()});
                delivered[i]++;
            end
            if (r_s[i])
                pulses[i]++;
        end
        @(posedge rclk);
        #1;
        for (int i = 0; i < 3; i++) begin
            cap       = (i == 1) ? r_s[i] : r_prev[i];
            r_prev[i] = (i == 1) ? 1'b0 : r_s[i];
            exp_l     = l_s[i] + int'(cap) - int'(acc[i]);
            chk("no_overflow", i, {31'd0, exp_l <= 3}, 32'd1);
            if (exp_l <= 3)
                chk("level_step", i, {30'd0, bl[i]}, 32'(exp_l));
            if (v_s[i] && !m_ready) begin
                chk("hold_valid", i, {31'd0, m_valid[i]}, 32'd1);
                chk("hold_data", i, {16'd0, m_data[i]}, {16'd0, d_s[i]});
            end
            chk("rd_count", i, cnt(i), (i == 2) ? 32'(delivered[2] % 16) : 32'(delivered[i]));
            if (r_s[i] && fq[i].size() != 0) begin
                w = fq[i].pop_front();
                if (i != 1)
                    rdata[i] = w;
            end
            refresh(i);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog");
        $fatal(1, "watchdog");
    end

    initial begin
        int p0 [3];
        int d0 [3];
        int pushed;
        int cyc;
        logic busy;

        tbl[0] = '{n: 0, first: 16'h0000, ready: 1'b1, cycles: 10, pulses: 0, level: 0, deliv: 0, chk_head: 1'b0, head: 16'h0000};
        tbl[1] = '{n: 8, first: 16'h0001, ready: 1'b0, cycles: 20, pulses: 3, level: 3, deliv: 0, chk_head: 1'b1, head: 16'h0001};
        tbl[2] = '{n: 0, first: 16'h0000, ready: 1'b1, cycles: 20, pulses: 5, level: 0, deliv: 8, chk_head: 1'b0, head: 16'h0000};
        tbl[3] = '{n: 1, first: 16'hBEEF, ready: 1'b1, cycles: 10, pulses: 1, level: 0, deliv: 1, chk_head: 1'b0, head: 16'h0000};

        for (int i = 0; i < 3; i++) pulses[i] = 0;
        clear_model();
        rrst_n  = 1'b0;
        m_ready = 1'b1;

        // Reset state, with a word waiting so the rinc gating is meaningful.
        #12;
        push(16'h1234);
        #1;
        for (int i = 0; i < 3; i++) begin
            chk("rst_rinc", i, {31'd0, rinc[i]}, 32'd0);
            chk("rst_valid", i, {31'd0, m_valid[i]}, 32'd0);
            chk("rst_data", i, {16'd0, m_data[i]}, 32'd0);
            chk("rst_level", i, {30'd0, bl[i]}, 32'd0);
            chk("rst_count", i, cnt(i), 32'd0);
        end
        clear_model();
        @(posedge rclk);
        #1;
        rrst_n = 1'b1;

        for (int r = 0; r < 4; r++) begin
            m_ready = tbl[r].ready;
            for (int k = 0; k < tbl[r].n; k++)
                push(tbl[r].first + 16'(k));
            for (int i = 0; i < 3; i++) begin
                p0[i] = pulses[i];
                d0[i] = delivered[i];
            end
            for (int c = 0; c < tbl[r].cycles; c++)
                cycle();
            for (int i = 0; i < 3; i++) begin
                chk("tbl_pulses", i, 32'(pulses[i] - p0[i]), 32'(tbl[r].pulses));
                chk("tbl_level", i, {30'd0, bl[i]}, 32'(tbl[r].level));
                chk("tbl_deliv", i, 32'(delivered[i] - d0[i]), 32'(tbl[r].deliv));
                if (tbl[r].chk_head)
                    chk("tbl_head", i, {16'd0, m_data[i]}, {16'd0, tbl[r].head});
            end
        end

        // Asynchronous reset mid-stream with two words buffered in the registered-read build.
        chk("pre_rst_count", 0, cnt_f, 32'd9);
        m_ready = 1'b0;
        for (int k = 0; k < 6; k++)
            push(16'h0100 + 16'(k));
        for (int c = 0; c < 3; c++)
            cycle();
        chk("pre_rst_level", 0, {30'd0, bl[0]}, 32'd2);
        #2;
        rrst_n = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk("async_valid", i, {31'd0, m_valid[i]}, 32'd0);
            chk("async_level", i, {30'd0, bl[i]}, 32'd0);
            chk("async_count", i, cnt(i), 32'd0);
            chk("async_rinc", i, {31'd0, rinc[i]}, 32'd0);
        end
        @(posedge rclk);
        #1;
        clear_model();
        m_ready = 1'b1;
        cycle();
        cycle();
        rrst_n = 1'b1;

        // Startup latency and back-to-back delivery, including the 4-bit counter wrap.
        p0[0] = pulses[0];
        for (int k = 1; k <= 16; k++)
            push(16'(k));
        cycle();
        chk("lat_true", 1, {31'd0, m_valid[1]}, 32'd1);
        chk("lat_false_early", 0, {31'd0, m_valid[0]}, 32'd0);
        cycle();
        chk("lat_false", 0, {31'd0, m_valid[0]}, 32'd1);
        for (int k = 0; k < 16; k++) begin
            chk("b2b_valid", 0, {31'd0, m_valid[0]}, 32'd1);
            if (k == 15)
                chk("cnt4_pre_wrap", 2, {28'd0, cnt_c}, 32'd15);
            cycle();
        end
        chk("b2b_count", 0, cnt_f, 32'd16);
        chk("cnt4_wrap", 2, {28'd0, cnt_c}, 32'd0);
        chk("b2b_pulses", 0, 32'(pulses[0] - p0[0]), 32'd16);
        chk("b2b_drained", 0, {31'd0, m_valid[0]}, 32'd0);

        // Random backpressure and random FIFO fill.
        for (int i = 0; i < 3; i++) d0[i] = delivered[i];
        pushed = 0;
        cyc    = 0;
        busy   = 1'b1;
        while (busy && cyc < 20000) begin
            m_ready = 1'($urandom_range(0, 1));
            if (pushed < 1000 && fq[0].size() < 16 && fq[1].size() < 16 && fq[2].size() < 16
                && $urandom_range(0, 2) == 0) begin
                for (int k = $urandom_range(1, 4); k > 0 && pushed < 1000; k--) begin
                    push(16'($urandom));
                    pushed++;
                end
            end
            cycle();
            cyc++;
            busy = (pushed < 1000) || sb[0].size() != 0 || sb[1].size() != 0 || sb[2].size() != 0;
        end
        if (busy)
            fail("random_timeout");
        for (int i = 0; i < 3; i++)
            chk("random_count", i, 32'(delivered[i] - d0[i]), 32'd1000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fifo_rd_stream.md
Name: fifo_rd_stream

Overview:
- Read-side drain stage placed directly downstream of the async FIFO, entirely in the read clock domain.
- Watches the FIFO's `rempty`, issues `rinc` pops and captures `rdata` into a 3-entry output buffer.
- Presents the words as a valid/ready stream (`m_valid`/`m_ready`/`m_data`).
- Keeps full one-word-per-cycle throughput with no combinational path from `m_ready` to `rinc`.
- Counts delivered words for debug.

Parameters:
- DSIZE, 16, data width; must equal the FIFO's DSIZE.
- FALLTHROUGH, "FALSE", FIFO read mode.
  - "FALSE": `rdata` is valid one `rclk` after `rinc`.
  - "TRUE": `rdata` is valid in the same cycle as `rinc` (show-ahead).
- CNTW, 32, width of the delivered-word counter.

Ports:
- rclk  input  1  read clock; all logic is on its rising edge.
- rrst_n  input  1  asynchronous active-low reset.
- rempty  input  1  FIFO empty flag (from the FIFO read side).
- rdata  input  DSIZE  FIFO read data.
- rinc  output  1  FIFO pop request.
- m_valid  output  1  stream data valid.
- m_ready  input  1  downstream accept.
- m_data  output  DSIZE  stream data (buffer head).
- rd_count  output  CNTW  words delivered (`m_valid` & `m_ready`), wrapping.
- buf_level  output  2  current buffer occupancy, 0..3.

Behaviour:
- Clock and reset: one clock (`rclk`); reset is asynchronous and active-low (`rrst_n`).
- Reset values (asserted asynchronously, released synchronously by the integrator):
  - occupancy 0, inflight 0, `m_valid` 0, `m_data` 0, `rd_count` 0, `buf_level` 0.
  - `rinc` 0 during reset.
  - Buffer storage entries reset to 0.
- Internal state:
  - `occ` (2 bits, 0..3): entries held in the buffer.
  - `inflight` (1 bit, FALLTHROUGH="FALSE" only): a pop was issued last cycle and its data arrives this cycle.
  - Buffer: 3-entry circular store with head and tail pointers (2 bits each, wrap 2→0).
- Pop issue (combinational from registered state plus `rempty` only):
  - `rinc` = !rempty && (occ + inflight < 3).
  - `rinc` must never be 1 while `rempty` = 1.
  - `rinc` must never depend on `m_ready`.
- Capture, FALLTHROUGH="FALSE":
  - `inflight` <= `rinc`.
  - When `inflight` = 1, `rdata` is written at the tail that cycle; tail++.
- Capture, FALLTHROUGH="TRUE":
  - `rdata` is written at the tail in the same cycle `rinc` = 1.
  - `inflight` is held at 0.
- Pop from buffer:
  - pop = m_valid && m_ready; head++.
  - `rd_count` += 1, wrapping modulo 2^CNTW.
- Occupancy update:
  - occ_next = occ + capture − pop.
  - Simultaneous capture and pop leaves `occ` unchanged; both pointers advance.
  - A pop with `occ` = 0 is impossible because `m_valid` = 0.
  - The credit rule guarantees a capture never finds `occ` = 3 (overflow cannot occur). The bench must assert this.
- Outputs:
  - `m_valid` = (occ != 0).
  - `m_data` = entry[head].
  - `buf_level` = `occ`.
  - All are registered state or a direct mux of registered state.
- Stream rules:
  - Once `m_valid` = 1, `m_data` must stay stable until accepted.
  - Word order equals FIFO order; no word is dropped or duplicated.
- Throughput:
  - With `rempty` = 0 and `m_ready` = 1 continuously, one word per cycle is delivered after the startup latency.
  - Startup latency, FALSE mode: `rempty` 1→0 seen at cycle t gives `rinc`@t, capture@t+1, `m_valid`@t+2.
  - Startup latency, TRUE mode: `m_valid`@t+1.
- Backpressure:
  - With `m_ready` = 0, at most 3 words are pulled (`occ` + `inflight` ≤ 3), then `rinc` stays 0.
  - When `m_ready` rises, issuing resumes in the cycle after the first pop.
- `rempty` rising while `inflight` = 1: the in-flight word is still captured.
- Reset mid-operation:
  - All buffered and in-flight words are discarded and `m_valid` drops immediately.
  - FIFO pointer consistency is the FIFO's own reset responsibility.

Test Plan:
1. Reset, hold `rempty` = 1, `m_ready` = 1 for 10 cycles → `rinc` = 0, `m_valid` = 0, `rd_count` = 0, `buf_level` = 0 throughout.
2. FALSE mode: FIFO preloaded with 0x0001..0x0010, `m_ready` = 1 → first `m_valid` 2 cycles after `rempty` falls. Then 16 back-to-back words 0x0001..0x0010 in order, `rd_count` = 16, `rinc` asserted for exactly 16 cycles.
3. Backpressure: 8 words queued, `m_ready` = 0 for 20 cycles → exactly 3 `rinc` pulses, `buf_level` = 3, `m_data` = 0x0001 stable. Then `m_ready` = 1 → remaining words delivered in order, no loss.
4. Random `m_ready` (50%) with random FIFO fill, 1000 words, both FALLTHROUGH settings → scoreboard order/data match, `rinc` never high with `rempty` high, `occ` never overflows.
5. `rempty` drops for one word only (0xBEEF), then rises → single capture, `m_valid` for exactly one accepted beat, `rd_count` +1.
6. Assert `rrst_n` = 0 asynchronously mid-stream with `buf_level` = 2 → `m_valid`, `buf_level`, `rd_count` go to 0 without waiting for a clock edge. Stream restarts cleanly after release. Additionally, preset `rd_count` near 2^CNTW−1 (CNTW=4 build) → wraps 15→0.
